// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants, FSM state type and instruction builders
// used by the load-immediate expander.
package rv32i_pkg;

   localparam logic [6:0]  OPC_LUI     = 7'b0110111;
   localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
   localparam logic [2:0]  FUNCT3_ADDI = 3'b000;
   localparam logic [31:0] NOP         = 32'h0000_0013;   // ADDI x0,x0,0

   // Legacy state encodings, kept so external probes see the same values
   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_FIRST_ENC  = 2'd1;
   localparam logic [1:0] ST_SECOND_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE_ENC,
      FIRST  = ST_FIRST_ENC,
      SECOND = ST_SECOND_ENC
   } state_t;

   typedef enum logic [1:0] {
      CLS_SHORT      = 2'd0,
      CLS_UPPER_ONLY = 2'd1,
      CLS_SPLIT      = 2'd2
   } imm_class_t;

   function automatic logic [31:0] enc_lui(input logic [19:0] imm20,
                                           input logic [4:0]  rd);
      return {imm20, rd, OPC_LUI};
   endfunction

   function automatic logic [31:0] enc_addi(input logic [11:0] imm12,
                                            input logic [4:0]  rs1,
                                            input logic [4:0]  rd);
      return {imm12, rs1, FUNCT3_ADDI, rd, OPC_OP_IMM};
   endfunction

endpackage

// File: rtl/imm_split.sv
// Splits a 32-bit constant into LUI/ADDI immediates and classifies how many
// instructions are needed to materialise it. Purely combinational.
module imm_split
   import rv32i_pkg::*;
(
   input  logic [31:0] value,
   output logic [19:0] hi,
   output logic [11:0] lo,
   output imm_class_t  cls
);

   // Immediate split and classification of the incoming constant
   always_comb begin
      // (value + 0x800) >> 12 mod 2^20: the carry out of bit 11 is exactly
      // value[11], so rounding reduces to adding that bit to the upper field.
      hi = value[31:12] + {19'd0, value[11]};
      lo = value[11:0];
      if ((value[31:11] == '0) || (value[31:11] == '1)) begin
         cls = CLS_SHORT;
      end else if (lo == '0) begin
         cls = CLS_UPPER_ONLY;
      end else begin
         cls = CLS_SPLIT;
      end
   end

endmodule

// File: rtl/li_expander.sv
// Load-immediate expander: turns a (rd, constant) request into one ADDI, one
// LUI, or an LUI+ADDI pair, presented one instruction at a time on a
// valid/ready output with registered outputs.
module li_expander
   import rv32i_pkg::*;
#(
   parameter int unsigned DATA_BUS_WIDTH = 32   // only 32 is supported
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [4:0]                in_rd,
   input  logic [DATA_BUS_WIDTH-1:0] in_value,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_BUS_WIDTH-1:0] out_instr,
   output logic                      out_last
);

   state_t      state;
   logic [4:0]  rd_q;
   logic [11:0] lo_q;

   logic [19:0] split_hi;
   logic [11:0] split_lo;
   imm_class_t  split_cls;
   logic        accept;

   imm_split u_imm_split (
      .value (in_value),
      .hi    (split_hi),
      .lo    (split_lo),
      .cls   (split_cls)
   );

   // Request handshake qualifier
   always_comb begin
      accept = in_valid && in_ready;
   end

   // Sequencer: registers the request and walks through its instruction(s)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_instr <= NOP;
         rd_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rd_q      <= in_rd;
                  lo_q      <= split_lo;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= FIRST;
                  case (split_cls)
                     CLS_SHORT: begin
                        out_instr <= enc_addi(split_lo, 5'd0, in_rd);
                        out_last  <= 1'b1;
                     end
                     CLS_UPPER_ONLY: begin
                        out_instr <= enc_lui(split_hi, in_rd);
                        out_last  <= 1'b1;
                     end
                     default: begin
                        out_instr <= enc_lui(split_hi, in_rd);
                        out_last  <= 1'b0;
                     end
                  endcase
               end else begin
                  in_ready <= 1'b1;
               end
            end

            FIRST: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_instr <= NOP;
                  end else begin
                     state     <= SECOND;
                     out_instr <= enc_addi(lo_q, rd_q, rd_q);
                     out_last  <= 1'b1;
                  end
               end
            end

            SECOND: begin
               if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  out_instr <= NOP;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               out_instr <= NOP;
            end
         endcase
      end
   end

endmodule

// File: doc/li_expander.md
LI_EXPANDER -- requirements
Module: li_expander

Interface
REQ-001 The module SHALL have parameter DATA_BUS_WIDTH, default 32, which is the constant and instruction width; only 32 is supported.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: a load-constant request is present.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The module SHALL have port in_rd, input, 5 bits: the destination register index.
REQ-007 The module SHALL have port in_value, input, DATA_BUS_WIDTH bits: the constant to materialize.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_instr holds a valid instruction.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer accepts out_instr.
REQ-010 The module SHALL have port out_instr, output, DATA_BUS_WIDTH bits: an RV32I LUI or ADDI encoding.
REQ-011 The module SHALL have port out_last, output, 1 bit: out_instr is the final instruction for the current request.

Function
REQ-012 The block SHALL decompose in_value into instructions whose 12-bit immediates, sign-extended, rebuild in_value exactly.
REQ-013 Requests SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-014 On acceptance, the block SHALL register in_rd and in_value and classify the constant:
- SHORT: in_value[31:11] is all-equal.
- UPPER_ONLY: not SHORT and in_value[11:0]=0.
- SPLIT: all other values.
REQ-015 The block SHALL compute hi = (in_value + 32'h800) >> 12 using 20-bit modulo arithmetic, and lo = in_value[11:0].
REQ-016 SHORT SHALL emit ADDI rd,x0,lo = {lo, 5'd0, 3'b000, rd, 7'b0010011} with out_last=1.
REQ-017 UPPER_ONLY SHALL emit LUI rd,hi = {hi, rd, 7'b0110111} with out_last=1.
REQ-018 SPLIT SHALL emit LUI rd,hi with out_last=0, then ADDI rd,rd,lo = {lo, rd, 3'b000, rd, 7'b0010011} with out_last=1.
REQ-019 The FSM SHALL use these states and transitions:
- IDLE to FIRST on acceptance.
- FIRST to IDLE on an out_ready handshake when out_last=1.
- FIRST to SECOND on an out_ready handshake when out_last=0.
- SECOND to IDLE on an out_ready handshake.
REQ-020 out_valid SHALL be 1 exactly in FIRST and SECOND, and outputs SHALL be registered; the first instruction appears in the cycle after acceptance, giving 1-cycle latency.
REQ-021 While out_valid=1 and out_ready=0, out_instr and out_last SHALL hold stable.
REQ-022 in_rd=0 SHALL be processed normally, with no special-casing.
REQ-023 Wrap-around SHALL be handled by the modulo arithmetic: a value near 32'h7FFFF800 gives hi=20'h80000, and the rebuilt value SHALL still equal in_value mod 2^32.
REQ-024 Throughput SHALL be one request per 2 cycles for SHORT/UPPER_ONLY and one per 3 cycles for SPLIT at out_ready=1; there is no back-to-back acceptance while busy.

Reset
REQ-025 On rst=1, the block SHALL immediately force state=IDLE, out_valid=0, out_last=0, out_instr=32'h00000013 (NOP), and in_ready=0.
REQ-026 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-027 A reset asserted mid-sequence SHALL discard the pending instruction with no partial emission afterward.

Structure
REQ-028 The opcodes OPC_LUI=7'b0110111, OPC_OP_IMM=7'b0010011, FUNCT3_ADDI=3'b000, and the NOP constant SHALL live in a shared package rv32i_pkg, together with the FSM state enum.
REQ-029 A combinational sub-module imm_split SHALL compute hi, lo and the classification; the FSM stays in li_expander.

Verification
REQ-030 The bench SHALL check: in_rd=5, in_value=32'h00000123 -> out_instr=32'h12300293, out_last=1, one cycle after acceptance.
REQ-031 The bench SHALL check: in_rd=5, in_value=32'hFFFFF800 -> out_instr=32'h80000293, out_last=1.
REQ-032 The bench SHALL check: in_rd=10, in_value=32'h12345678 -> 32'h12345537 (last=0), then 32'h67850513 (last=1).
REQ-033 The bench SHALL check: in_rd=1, in_value=32'h00001800 -> 32'h000020B7, then 32'h80008093 (lo negative, hi rounded up).
REQ-034 The bench SHALL check: in_rd=1, in_value=32'h00005000 -> single 32'h000050B7 with last=1; with out_ready held 0 for 3 cycles, out_instr stays stable and in_ready stays 0.
REQ-035 The bench SHALL check: rst asserted while SECOND is pending -> out_valid=0 the same cycle, no ADDI emitted, and in_ready=1 after release.
